mux_arbiter: RTL and testbench

- Gathers N independent producer channels onto one shared data bus. This is the many-to-one counterpart of the processor's one-to-many demux.
- Uses fair round-robin arbitration and a valid/ready handshake on every channel.
- Output is registered. The consumer sees one word per cycle plus the index of the channel that sourced it.
- Used wherever several units (e.g. functional units to writeback) compete for a single bus.

---
 rtl/mux_arbiter_pkg.sv | 21 ++
 rtl/mux_arbiter_pick.sv | 32 +++
 rtl/mux_arbiter.sv | 71 +++++++
 tb/tb_mux_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared helpers for the mux_arbiter block: index arithmetic that must stay
// correct for channel counts that are not a power of two.
package mux_arbiter_pkg;

  // Advance a channel index by one, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) nxt = 0;
    return nxt;
  endfunction

  // Add an offset to a base index modulo n, with both operands already in [0, n).
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/mux_arbiter_pick.sv
// Combinational round-robin picker: rotates the request vector so the pointer
// lands on bit 0, takes the lowest set bit, then rotates the answer back.
module rr_pick
  import mux_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_W-1:0]      ptr,
  output logic                  any_req,
  output logic [SEL_W-1:0]      grant
);

  logic [NUM_INPUTS-1:0] rot;
  int                    off;

  always_comb begin
    rot = '0;
    off = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rot[i] = req[wrap_add(int'(ptr), i, NUM_INPUTS)];
    end
    // Scan downward so the lowest rotated position (closest to ptr) wins.
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    any_req = |rot;
    grant   = SEL_W'(wrap_add(int'(ptr), off, NUM_INPUTS));
  end

endmodule

// File: rtl/mux_arbiter.sv
// Many-to-one bus arbiter: fair round-robin grant over NUM_INPUTS valid/ready
// producers into a single registered output word tagged with its source index.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
  output logic [NUM_INPUTS-1:0]            o_ready,
  output logic                             o_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [$clog2(NUM_INPUTS)-1:0]    o_select,
  input  logic                             i_ready
);

  localparam int SEL_W = $clog2(NUM_INPUTS);

  logic                  load;
  logic                  any_req;
  logic [SEL_W-1:0]      grant;
  logic [SEL_W-1:0]      ptr;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [SEL_W-1:0]      sel_p1;

  rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_W      (SEL_W)
  ) u_pick (
    .req     (i_valid),
    .ptr     (ptr),
    .any_req (any_req),
    .grant   (grant)
  );

  // The output register can take a word when empty or when being drained now.
  assign load = ~vld_p1 | i_ready;

  always_comb begin
    o_ready = '0;
    if (!i_rst && load && any_req) o_ready[grant] = 1'b1;
  end

  // Stage p0 -> p1: capture the granted word into the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any_req) begin
        vld_p1  <= 1'b1;
        data_p1 <= i_data_bus[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        sel_p1  <= grant;
        ptr     <= SEL_W'(wrap_inc(int'(grant), NUM_INPUTS));
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign o_valid  = vld_p1;
  assign o_data   = data_p1;
  assign o_select = sel_p1;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter (5 channels x 8 bits): directed scenarios
// followed by a randomized stretch, all checked against a behavioural model.
module tb_mux_arbiter;

  localparam int N  = 5;
  localparam int DW = 8;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_valid;
  logic [N*DW-1:0] i_data_bus;
  logic [N-1:0]    o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [2:0]      o_select;
  logic            i_ready;

  typedef struct {
    logic [DW-1:0] d;
    int            s;
  } word_t;

  word_t         sb[$];
  logic [N-1:0]  pend;
  logic [DW-1:0] word [N];
  logic [N-1:0]  dut_fire;
  int            mptr;
  int            checks;
  int            errors;

  logic [N-1:0]  s_ready;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [2:0]    s_sel;

  logic [N-1:0]  pv;
  logic [N-1:0]  pf;
  logic [DW-1:0] pd [N];

  mux_arbiter #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_select   (o_select),
    .i_ready    (i_ready)
  );

  always #5 i_clk = ~i_clk;

  assign i_valid = pend;

  always_comb begin
    i_data_bus = '0;
    for (int k = 0; k < N; k++) i_data_bus[k*DW +: DW] = word[k];
  end

  // Producer stability: a word offered without a handshake must stay put.
  always @(negedge i_clk) begin
    for (int k = 0; k < N; k++) begin
      if (pv[k] && !pf[k]) begin
        assert (i_valid[k] && (i_data_bus[k*DW +: DW] == pd[k]))
          else $error("producer %0d changed its word before transfer", k);
      end
      pd[k] = i_data_bus[k*DW +: DW];
    end
    pv = i_valid;
    pf = i_valid & o_ready;
  end

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: sample mid-cycle, check against the model, advance the model,
  // then let producers retire words that were handshaken on the edge.
  task automatic cycle();
    int            g;
    bit            any;
    bit            ld;
    logic [N-1:0]  er;
    @(negedge i_clk);
    s_ready = o_ready;
    s_valid = o_valid;
    s_data  = o_data;
    s_sel   = o_select;
    any = 1'b0;
    g   = 0;
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (mptr + j) % N;
      if (!any && i_valid[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    ld = (sb.size() == 0) || i_ready;
    er = (!i_rst && ld && any) ? N'(1 << g) : '0;
    chk_val("o_ready", 32'(o_ready), 32'(er));
    chk_val("o_valid", 32'(o_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk_val("o_data", 32'(o_data), 32'(sb[0].d));
      chk_val("o_select", 32'(o_select), 32'(sb[0].s));
    end
    dut_fire = i_valid & o_ready;
    if (i_rst) begin
      sb.delete();
      mptr = 0;
    end else if (ld) begin
      if (sb.size() != 0) void'(sb.pop_front());
      if (any) begin
        sb.push_back('{word[g], g});
        mptr = (g + 1) % N;
      end
    end
    @(posedge i_clk);
    #1;
    for (int k = 0; k < N; k++) if (dut_fire[k]) pend[k] = 1'b0;
  endtask

  initial begin
    logic [2:0]    rr_sel [5];
    checks = 0;
    errors = 0;
    mptr   = 0;
    pv     = '0;
    pf     = '0;
    i_rst   = 1'b1;
    i_ready = 1'b1;
    pend    = '1;
    for (int k = 0; k < N; k++) word[k] = DW'(8'h20 + k);
    @(posedge i_clk);
    #1;

    // Reset held with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk_val("rst_ready", 32'(s_ready), 32'h0);
      chk_val("rst_valid", 32'(s_valid), 32'h0);
      chk_val("rst_data", 32'(s_data), 32'h0);
      chk_val("rst_sel", 32'(s_sel), 32'h0);
    end
    i_rst = 1'b0;
    cycle();
    chk_val("post_rst_ready", 32'(s_ready), 32'h01);
    for (int c = 0; c < 6; c++) cycle();

    // Single channel 2.
    pend[2] = 1'b1;
    word[2] = 8'hAA;
    cycle();
    chk_val("single_ready", 32'(s_ready), 32'h04);
    cycle();
    chk_val("single_valid", 32'(s_valid), 32'h1);
    chk_val("single_data", 32'(s_data), 32'hAA);
    chk_val("single_sel", 32'(s_sel), 32'h2);

    // Round robin from ptr=3 with wrap.
    pend = '1;
    for (int k = 0; k < N; k++) word[k] = DW'(8'h10 + k);
    rr_sel[0] = 3'd3; rr_sel[1] = 3'd4; rr_sel[2] = 3'd0; rr_sel[3] = 3'd1; rr_sel[4] = 3'd2;
    cycle();
    chk_val("rr_first_ready", 32'(s_ready), 32'h08);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk_val("rr_valid", 32'(s_valid), 32'h1);
      chk_val("rr_sel", 32'(s_sel), 32'(rr_sel[i]));
      chk_val("rr_data", 32'(s_data), 32'(8'h10 + rr_sel[i]));
    end
    cycle();
    chk_val("idle_valid", 32'(s_valid), 32'h0);
    chk_val("idle_sel_hold", 32'(s_sel), 32'h2);

    // Backpressure: 0x55 from channel 1 held while channels 0 and 3 wait.
    pend[1] = 1'b1;
    word[1] = 8'h55;
    cycle();
    i_ready = 1'b0;
    pend[0] = 1'b1; word[0] = 8'hA0;
    pend[3] = 1'b1; word[3] = 8'hA3;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk_val("bp_ready", 32'(s_ready), 32'h0);
      chk_val("bp_data", 32'(s_data), 32'h55);
      chk_val("bp_sel", 32'(s_sel), 32'h1);
    end
    i_ready = 1'b1;
    cycle();
    chk_val("bp_release_ready", 32'(s_ready), 32'h08);
    cycle();
    chk_val("bp_refill_data", 32'(s_data), 32'hA3);
    chk_val("bp_refill_sel", 32'(s_sel), 32'h3);
    cycle();
    chk_val("bp_next_sel", 32'(s_sel), 32'h0);
    cycle();

    // Reset while a word is held and channel 4 is requesting.
    pend[1] = 1'b1;
    word[1] = 8'h77;
    cycle();
    i_ready = 1'b0;
    pend[4] = 1'b1;
    word[4] = 8'hC4;
    i_rst   = 1'b1;
    cycle();
    chk_val("mid_rst_ready", 32'(s_ready), 32'h0);
    chk_val("mid_rst_held", 32'(s_valid), 32'h1);
    i_rst = 1'b0;
    cycle();
    chk_val("after_rst_valid", 32'(s_valid), 32'h0);
    chk_val("after_rst_ready", 32'(s_ready), 32'h10);
    cycle();
    chk_val("after_rst_data", 32'(s_data), 32'hC4);
    chk_val("after_rst_sel", 32'(s_sel), 32'h4);

    // Randomized traffic and backpressure against the model.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
          pend[k] = 1'b1;
          word[k] = DW'($urandom);
        end
      end
      i_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
